lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory stage of the RV32I pipeline, directly downstream of the execute stage. It consumes the ALU result as either a pass-through writeback value or a load/store address, and drives a request/grant/response data-memory port. Store data is byte-lane aligned, and load data is lane-extracted and sign/zero-extended. `o_stall` holds upstream for the whole multi-cycle memory access. Outputs are registered and feed writeback.

## Interface
No parameters.
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: the execute stage presents an instruction this cycle.
- `i_mem_read` in 1: the instruction is a load.
- `i_mem_write` in 1: the instruction is a store. Never high together with `i_mem_read`.
- `i_funct3` in 3: access size and sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Any other code is treated as a word access.
- `i_addr` in 32: ALU result, used as the address or as the pass-through value.
- `i_store_data` in 32: rs2 data.
- `i_rd` in 5: destination register.
- `o_stall` out 1: upstream must hold all inputs stable while this is high.
- `o_dmem_req` out 1: memory request.
- `i_dmem_gnt` in 1: request accepted this cycle.
- `o_dmem_addr` out 32: word address, `{i_addr[31:2], 2'b00}`.
- `o_dmem_we` out 1: high for a store.
- `o_dmem_wdata` out 32: lane-replicated store data.
- `o_dmem_wmask` out 4: byte enables.
- `i_dmem_rvalid` in 1: load data is valid.
- `i_dmem_rdata` in 32: load data word.
- `o_wb_valid` out 1: writeback entry is valid.
- `o_wb_data` out 32: writeback value.
- `o_wb_rd` out 5: writeback register. Forced to 0 for stores.
- `o_misaligned` out 1: one-cycle misalignment fault pulse. Present only with `LSU_MISALIGN_TRAP_EN`.

## Operation
- **FSM states:** IDLE, REQ, WAIT.
- **Capture:** entering REQ latches address, size, store data, rd and read/write.
- **IDLE, non-memory instruction:** `i_valid` high with no memory op registers `o_wb_data=i_addr`, `o_wb_rd=i_rd` and `o_wb_valid=1` at the next edge. No stall is asserted.
- **IDLE, memory op:** the state moves to REQ at the next edge. `o_stall=1`.
- **REQ:**
  - `o_dmem_req=1` until `i_dmem_gnt` is high.
  - A store completes on the gnt cycle: next state IDLE, `o_wb_valid=1`, `o_wb_rd=0`.
  - A load moves to WAIT on gnt.
- **WAIT:** on `i_dmem_rvalid` the extracted data is registered into `o_wb_data` with `o_wb_valid=1`, and the state returns to IDLE.
- **Stall rule:** `o_stall = (IDLE & i_valid & mem_op & ~fault) | (REQ & ~(store & gnt)) | (WAIT & ~rvalid)`.
  - `o_stall` is low in the completion cycle, so upstream advances at that edge and the same instruction is never reissued.
- **Write mask:**
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `4'b0011 << {addr[1],1'b0}`.
  - SW: `4'b1111`.
- **Write data:**
  - SB: `{4{rs2[7:0]}}`.
  - SH: `{2{rs2[15:0]}}`.
  - SW: `rs2`.
- **Load extraction:**
  - Byte: `rdata[8*addr[1:0] +: 8]`.
  - Half: `rdata[16*addr[1] +: 16]`.
  - LB and LH sign-extend. LBU and LHU zero-extend.
- **Request outputs:** `o_dmem_addr/we/wdata/wmask` are driven from the captured registers and are valid whenever `o_dmem_req=1`.
- **Single-cycle `o_wb_valid`:** `o_wb_valid` is high for one cycle per completed instruction. It is 0 in all other cycles.
- **Pass-through hold:** `o_wb_data` and `o_wb_rd` hold their values when `o_wb_valid=0`.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Reset mid-operation:** asserting `i_rst_n=0` in any state immediately drops `o_dmem_req`, and any outstanding response is ignored after release.
- **Pass-through latency:** 1 cycle.
- **Store latency:** 2 cycles minimum, IDLE then REQ with gnt. `o_wb_valid` is high in the cycle after gnt.
- **Load latency:** 3 cycles minimum when gnt arrives in the first REQ cycle and rvalid in the next. `o_wb_valid` is high in the cycle after rvalid.
- **Wait states:** each extra cycle without gnt or rvalid adds one cycle.
- **rvalid with gnt:** `i_dmem_rvalid` in the same cycle as gnt is ignored. A response is accepted only in WAIT.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** a halfword with `addr[0]=1` or a word with `addr[1:0]!=0` does the following:
  - issues no memory request;
  - pulses `o_misaligned=1` for one cycle, registered at the next edge;
  - sets `o_wb_valid=0`;
  - does not assert `o_stall`.
- **`LSU_MISALIGN_TRAP_EN` undefined:** the port is absent.
  - Halfword accesses ignore `addr[0]` and word accesses ignore `addr[1:0]`.
  - The access proceeds aligned down.

## Test plan
- **Pass-through:** `i_valid=1`, no memory op, `i_addr=0x12345678`, `rd=5` -> next cycle `o_wb_valid=1`, `o_wb_data=0x12345678`, `o_wb_rd=5`, `o_stall` never high.
- **SB:** addr=0x1003, rs2=0xAABBCCDD, gnt on the first REQ cycle -> `o_dmem_addr=0x1000`, `wmask=4'b1000`, `wdata=0xDDDDDDDD`, `we=1`; `o_wb_valid` high the next cycle with `rd=0`.
- **LB then LBU:** rdata=0x80FF7F01, addr[1:0]=2 -> LB gives 0xFFFFFFFF and LBU gives 0x000000FF; with addr[1:0]=3, LB gives 0xFFFFFF80.
- **Wait states on LH:** gnt delayed 2 cycles and rvalid delayed 3 cycles; addr=0x2002, rdata=0x8001xxxx -> `o_stall` high throughout, `o_wb_data=0xFFFF8001` exactly once.
- **Reset mid-operation:** `i_rst_n` low while in WAIT -> `o_dmem_req=0` and all outputs 0 immediately; after release a late rvalid produces no `o_wb_valid`.
- **Misalignment fault:** with `LSU_MISALIGN_TRAP_EN`, LW at 0x1002 -> `o_misaligned` pulses one cycle, `o_dmem_req` stays 0. Without the macro the same access reads 0x1000.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Execute-to-memory stage bundle: upstream instruction, data-memory port and writeback outputs.
// o_misaligned exists only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_mem_stage_if;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic [4:0]  i_rd;
    logic        o_stall;
    logic        o_dmem_req;
    logic        i_dmem_gnt;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_we;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_wmask;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif

    modport slave (
        input  i_valid, i_mem_read, i_mem_write, i_funct3, i_addr, i_store_data, i_rd,
        input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
        output o_stall, o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_wdata, o_dmem_wmask,
`ifdef LSU_MISALIGN_TRAP_EN
        output o_misaligned,
`endif
        output o_wb_valid, o_wb_data, o_wb_rd
    );

    modport master (
        output i_valid, i_mem_read, i_mem_write, i_funct3, i_addr, i_store_data, i_rd,
        output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
        input  o_stall, o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_wdata, o_dmem_wmask,
`ifdef LSU_MISALIGN_TRAP_EN
        input  o_misaligned,
`endif
        input  o_wb_valid, o_wb_data, o_wb_rd
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I memory stage: pass-through or load/store over a req/gnt/rvalid port, registered writeback.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of aligning down.
module lsu_mem_stage (
    input  logic           i_clk,
    input  logic           i_rst_n,
    lsu_mem_stage_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_sdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_we;
    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;

    logic        w_mem_op, w_fault, w_req, w_stall;
    logic        w_capture, w_pass, w_store_done, w_load_done;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata, w_ldata;
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;

    assign w_mem_op = bus.i_mem_read | bus.i_mem_write;

    // funct3[1:0] alone selects the size: 00 byte, 01 half, 1x word (covers the undefined codes)
`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misaligned;
    assign w_fault = w_mem_op &
                     (((bus.i_funct3[1:0] == 2'b01) & bus.i_addr[0]) |
                      (bus.i_funct3[1] & (|bus.i_addr[1:0])));
`else
    assign w_fault = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_capture    = 1'b0;
        w_pass       = 1'b0;
        w_store_done = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_valid && !w_mem_op) begin
                    w_pass = 1'b1;
                end else if (bus.i_valid && !w_fault) begin
                    w_capture = 1'b1;
                    w_stall   = 1'b1;
                    w_next    = S_REQ;
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (bus.i_dmem_gnt && r_we) begin
                    w_store_done = 1'b1;
                    w_next       = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (bus.i_dmem_gnt) w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_dmem_rvalid) begin
                    w_load_done = 1'b1;
                    w_next      = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr   <= '0;
            r_sdata  <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_we     <= 1'b0;
        end else if (w_capture) begin
            r_addr   <= bus.i_addr;
            r_sdata  <= bus.i_store_data;
            r_funct3 <= bus.i_funct3;
            r_rd     <= bus.i_rd;
            r_we     <= bus.i_mem_write;
        end
    end

    // Byte enables are gated by r_we so the port idles at all-zero after reset
    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = r_sdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_wmask = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_sdata[7:0]}};
            end
            2'b01: begin
                w_wmask = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_sdata[15:0]}};
            end
            default: w_wmask = 4'b1111;
        endcase
        if (!r_we) w_wmask = 4'b0000;
    end

    assign w_lbyte = bus.i_dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_lhalf = bus.i_dmem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_ldata = {{24{~r_funct3[2] & w_lbyte[7]}}, w_lbyte};
            2'b01:   w_ldata = {{16{~r_funct3[2] & w_lhalf[15]}}, w_lhalf};
            default: w_ldata = bus.i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
        end else begin
            r_wb_valid <= w_pass | w_store_done | w_load_done;
            if (w_pass) begin
                r_wb_data <= bus.i_addr;
                r_wb_rd   <= bus.i_rd;
            end else if (w_store_done) begin
                r_wb_rd   <= '0;
            end else if (w_load_done) begin
                r_wb_data <= w_ldata;
                r_wb_rd   <= r_rd;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_misaligned <= 1'b0;
        else          r_misaligned <= (r_state == S_IDLE) & bus.i_valid & w_fault;
    end
    assign bus.o_misaligned = r_misaligned;
`endif

    // Stall is masked during reset so every output reads 0 while i_rst_n is low
    assign bus.o_stall      = w_stall & i_rst_n;
    assign bus.o_dmem_req   = w_req;
    assign bus.o_dmem_addr  = {r_addr[31:2], 2'b00};
    assign bus.o_dmem_we    = r_we;
    assign bus.o_dmem_wdata = w_wdata;
    assign bus.o_dmem_wmask = w_wmask;
    assign bus.o_wb_valid   = r_wb_valid;
    assign bus.o_wb_data    = r_wb_data;
    assign bus.o_wb_rd      = r_wb_rd;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: driver pushes expected writebacks/requests, memory
// responder and writeback monitor pop and compare against a size/offset arithmetic model.
module tb_lsu_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_stage_if bus();

    lsu_mem_stage dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        bit          st;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          d;
        int          r;
        logic [31:0] rdata;
        bit          early;
    } rq_t;

    wb_t wbq[$];
    rq_t rqq[$];

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_rd = '0;
    bit          data_known = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_total++;
        $display("FAIL %s: event outside expected behaviour", nm);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic int offset_of(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_of(f3);
        return (sz == 4) ? 0 : (int'(a % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * offset_of(f3, a));
        if (size_of(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else if (size_of(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic bit is_fault(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % size_of(f3)) != 0;
`else
        return (f3 == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Memory responder: checks each request, then plays gnt/rvalid with the chosen delays
    initial begin
        rq_t e;
        bus.i_dmem_gnt = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.o_dmem_req) continue;
            if (rqq.size() == 0) begin
                fail("dmem_req_unexpected");
                continue;
            end
            e = rqq.pop_front();
            chk("dmem_addr", bus.o_dmem_addr, e.addr);
            chk("dmem_we", {31'd0, bus.o_dmem_we}, {31'd0, e.we});
            if (e.we) begin
                chk("dmem_wmask", {28'd0, bus.o_dmem_wmask}, {28'd0, e.mask});
                chk("dmem_wdata", bus.o_dmem_wdata, e.wdata);
            end
            repeat (e.d) @(negedge clk);
            bus.i_dmem_gnt = 1'b1;
            if (e.early) begin
                bus.i_dmem_rvalid = 1'b1;
                bus.i_dmem_rdata = ~e.rdata;
            end
            @(negedge clk);
            bus.i_dmem_gnt = 1'b0;
            bus.i_dmem_rvalid = 1'b0;
            if (!e.we) begin
                repeat (e.r) @(negedge clk);
                bus.i_dmem_rvalid = 1'b1;
                bus.i_dmem_rdata = e.rdata;
                @(negedge clk);
                bus.i_dmem_rvalid = 1'b0;
            end
        end
    end

    // Writeback monitor: one pop per o_wb_valid, hold check otherwise
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (bus.o_wb_valid) begin
                if (wbq.size() == 0) begin
                    fail("wb_valid_unexpected");
                end else begin
                    e = wbq.pop_front();
                    chk("wb_rd", {27'd0, bus.o_wb_rd}, {27'd0, e.rd});
                    last_rd = e.rd;
                    if (e.st) begin
                        data_known = 1'b0;
                    end else begin
                        chk("wb_data", bus.o_wb_data, e.data);
                        last_data = e.data;
                        data_known = 1'b1;
                    end
                end
            end else begin
                chk("wb_rd_hold", {27'd0, bus.o_wb_rd}, {27'd0, last_rd});
                if (data_known) chk("wb_data_hold", bus.o_wb_data, last_data);
            end
        end
    end

    task automatic issue(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input int d, input int r,
                         input logic [31:0] rdata, input bit early);
        wb_t w;
        rq_t q;
        int sz, off, cnt, exp_cnt;
        bit flt;
        sz = size_of(f3);
        off = offset_of(f3, a);
        flt = (mr || mw) && is_fault(f3, a);
        exp_cnt = 0;
        if (!mr && !mw) begin
            w.data = a; w.rd = rd; w.st = 1'b0;
            wbq.push_back(w);
        end else if (!flt) begin
            q.addr = a - (a % 4);
            q.we = mw;
            q.mask = 4'((32'd1 << sz) - 1) << off;
            q.wdata = (sz == 1) ? sd[7:0] * 32'h01010101 :
                      (sz == 2) ? sd[15:0] * 32'h00010001 : sd;
            q.d = d; q.r = r; q.rdata = rdata; q.early = early;
            rqq.push_back(q);
            w.data = mw ? 32'd0 : load_model(f3, a, rdata);
            w.rd = mw ? 5'd0 : rd;
            w.st = mw;
            wbq.push_back(w);
            exp_cnt = mw ? 1 + d : 2 + d + r;
        end
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_mem_read = mr;
        bus.i_mem_write = mw;
        bus.i_funct3 = f3;
        bus.i_addr = a;
        bus.i_store_data = sd;
        bus.i_rd = rd;
        cnt = 0;
        #1;
        while (bus.o_stall) begin
            cnt++;
            if (cnt > 40) begin
                fail("stall_timeout");
                $display("FAIL stall_timeout: stall stuck high");
                $fatal(1);
            end
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", cnt, exp_cnt);
        if (flt) begin
            @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
            chk("misaligned_pulse", {31'd0, bus.o_misaligned}, 32'd1);
`endif
            chk("fault_no_req", {31'd0, bus.o_dmem_req}, 32'd0);
            bus.i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        @(negedge clk);
        bus.i_valid = 1'b0;
        t = 0;
        while ((wbq.size() != 0 || rqq.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("wbq_empty", wbq.size(), 0);
        chk("rqq_empty", rqq.size(), 0);
    endtask

    initial begin
        logic [2:0] lf [8];
        logic [2:0] f3;
        logic [31:0] a;
        int kind;
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4;
        lf[4] = 3'd5; lf[5] = 3'd3; lf[6] = 3'd6; lf[7] = 3'd7;
        bus.i_valid = 1'b0;
        bus.i_mem_read = 1'b0;
        bus.i_mem_write = 1'b0;
        bus.i_funct3 = '0;
        bus.i_addr = '0;
        bus.i_store_data = '0;
        bus.i_rd = '0;
        #1;
        chk("rst_req", {31'd0, bus.o_dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.o_wb_valid}, 32'd0);
        chk("rst_wb_data", bus.o_wb_data, 32'd0);
        chk("rst_dmem_addr", bus.o_dmem_addr, 32'd0);
        chk("rst_wmask", {28'd0, bus.o_dmem_wmask}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(0, 0, 3'd0, 32'h12345678, 32'd0, 5'd5, 0, 0, 32'd0, 0);
        issue(0, 1, 3'd0, 32'h00001003, 32'hAABBCCDD, 5'd9, 0, 0, 32'd0, 0);
        issue(1, 0, 3'd0, 32'h00000402, 32'd0, 5'd3, 0, 0, 32'h80FF7F01, 0);
        issue(1, 0, 3'd4, 32'h00000402, 32'd0, 5'd4, 0, 0, 32'h80FF7F01, 0);
        issue(1, 0, 3'd0, 32'h00000403, 32'd0, 5'd6, 0, 0, 32'h80FF7F01, 1);
        issue(1, 0, 3'd1, 32'h00002002, 32'd0, 5'd8, 2, 3, 32'h80011234, 0);
        issue(1, 0, 3'd2, 32'h00001002, 32'd0, 5'd10, 0, 0, 32'hCAFEF00D, 0);
        issue(0, 1, 3'd1, 32'h00000042, 32'h11223344, 5'd2, 1, 0, 32'd0, 1);
        drain();

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            f3 = (kind == 2) ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 7)];
            issue(kind == 1, kind == 2, f3, a, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
        end
        drain();

        // Reset while in WAIT; the responder's rvalid then lands after release
        begin
            rq_t q;
            q.addr = 32'h3000; q.we = 1'b0; q.mask = '0; q.wdata = '0;
            q.d = 0; q.r = 5; q.rdata = 32'h55; q.early = 1'b0;
            rqq.push_back(q);
            @(negedge clk);
            bus.i_valid = 1'b1; bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b0;
            bus.i_funct3 = 3'd2; bus.i_addr = 32'h3000; bus.i_rd = 5'd7;
            @(negedge clk);
            @(negedge clk);
            #3;
            rst_n = 1'b0;
            bus.i_valid = 1'b0;
            last_data = '0; last_rd = '0; data_known = 1'b1;
            #1;
            chk("midrst_req", {31'd0, bus.o_dmem_req}, 32'd0);
            chk("midrst_stall", {31'd0, bus.o_stall}, 32'd0);
            chk("midrst_wb_data", bus.o_wb_data, 32'd0);
            chk("midrst_dmem_addr", bus.o_dmem_addr, 32'd0);
            @(negedge clk);
            #3;
            rst_n = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("midrst_no_wb", {31'd0, bus.o_wb_valid}, 32'd0);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
